fft16: RTL and testbench

- Streaming 16-point complex FFT on a real-valued, signed 16-bit fixed-point sample stream.
- Consecutive samples are grouped into non-overlapping frames of 16. For each complete frame the block emits all 16 frequency bins in parallel, with a one-cycle valid strobe.
- Sits downstream of the FIR filter in the spectrum-analysis path. A done flag tells the system that the final frame has been delivered.

---
 rtl/fft16_pkg.sv | 49 ++++
 rtl/fft16_butterfly.sv | 32 +++
 rtl/fft16.sv | 153 +++++++++++++++
 tb/tb_fft16.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared widths, complex types, twiddle table and helpers for the 16-point FFT.
package fft16_pkg;
  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int TW      = 18;
  localparam int IW      = 24;
  localparam int IFRAC   = 8;
  localparam int TW_FRAC = 16;
  localparam int N       = 16;

  typedef struct packed {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW-1:0] re;
    logic signed [TW-1:0] im;
  } twid_t;

  localparam logic signed [IW-1:0] SAT_MAX = IW'(2 ** (DW - 1) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(2 ** (DW - 1)));

  // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), scaled by 2^16 and rounded.
  function automatic twid_t twiddle(input logic [2:0] k);
    twid_t w;
    case (k)
      3'd0:    w = '{re:  18'sd65536, im:  18'sd0};
      3'd1:    w = '{re:  18'sd60547, im: -18'sd25080};
      3'd2:    w = '{re:  18'sd46341, im: -18'sd46341};
      3'd3:    w = '{re:  18'sd25080, im: -18'sd60547};
      3'd4:    w = '{re:  18'sd0,     im: -18'sd65536};
      3'd5:    w = '{re: -18'sd25080, im: -18'sd60547};
      3'd6:    w = '{re: -18'sd46341, im: -18'sd46341};
      default: w = '{re: -18'sd60547, im: -18'sd25080};
    endcase
    return w;
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  function automatic logic [DW-1:0] sat16(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction
endpackage

// File: rtl/fft16_butterfly.sv
// Radix-2 DIT butterfly: p = a + W*b, m = a - W*b, product rounded half-up.
module fft16_butterfly
  import fft16_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  twid_t w,
  output cplx_t p,
  output cplx_t m
);
  localparam int PW = IW + TW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW_FRAC - 1));

  logic signed [PW-1:0] br, bi, wr, wi;
  logic signed [PW-1:0] pr, pi, rr, ri;
  logic signed [IW-1:0] tr, ti;

  assign br = PW'(b.re);
  assign bi = PW'(b.im);
  assign wr = PW'(w.re);
  assign wi = PW'(w.im);

  assign pr = br * wr - bi * wi;
  assign pi = br * wi + bi * wr;
  assign rr = pr + HALF;
  assign ri = pi + HALF;
  assign tr = rr[TW_FRAC+IW-1:TW_FRAC];
  assign ti = ri[TW_FRAC+IW-1:TW_FRAC];

  assign p = '{re: a.re + tr, im: a.im + ti};
  assign m = '{re: a.re - tr, im: a.im - ti};
endmodule

// File: rtl/fft16.sv
// Streaming 16-point FFT: double-buffered capture, one DIT stage per cycle, saturated Q8.8 bins.
module fft16
  import fft16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DW-1:0]     data,
  output logic              fft_valid,
  output logic [2*DW-1:0]   fft_d0,
  output logic [2*DW-1:0]   fft_d1,
  output logic [2*DW-1:0]   fft_d2,
  output logic [2*DW-1:0]   fft_d3,
  output logic [2*DW-1:0]   fft_d4,
  output logic [2*DW-1:0]   fft_d5,
  output logic [2*DW-1:0]   fft_d6,
  output logic [2*DW-1:0]   fft_d7,
  output logic [2*DW-1:0]   fft_d8,
  output logic [2*DW-1:0]   fft_d9,
  output logic [2*DW-1:0]   fft_d10,
  output logic [2*DW-1:0]   fft_d11,
  output logic [2*DW-1:0]   fft_d12,
  output logic [2*DW-1:0]   fft_d13,
  output logic [2*DW-1:0]   fft_d14,
  output logic [2*DW-1:0]   fft_d15,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE, S_STAGE, S_OUT} state_t;

  logic [3:0]      cnt;
  logic [DW-1:0]   in_buf [N];
  logic            frame_rdy;
  logic            seen;
  state_t          state;
  logic [1:0]      stage;
  cplx_t           cbuf [N];
  cplx_t           nxt [N];
  logic [2*DW-1:0] fft_r [N];

  logic [3:0] idx_a [8];
  logic [3:0] idx_b [8];
  logic [2:0] idx_w [8];
  cplx_t      bf_a [8];
  cplx_t      bf_b [8];
  cplx_t      bf_p [8];
  cplx_t      bf_m [8];
  twid_t      bf_w [8];

  always_ff @(posedge clk) begin
    if (data_valid) in_buf[cnt] <= data;
  end

  // frame_rdy pulses the cycle after slot 15 is written; the engine copies the buffer then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      frame_rdy <= 1'b0;
      seen      <= 1'b0;
    end else begin
      frame_rdy <= data_valid && (cnt == 4'd15);
      if (data_valid) begin
        cnt  <= cnt + 4'd1;
        seen <= 1'b1;
      end
    end
  end

  // Stage s pairs elements 2^s apart; twiddle index is the in-group position scaled to W^0..W^7.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      idx_a[i] = 4'(((i >> stage) << (stage + 1)) | (i & ((1 << stage) - 1)));
      idx_b[i] = idx_a[i] | 4'(1 << stage);
      idx_w[i] = 3'((i & ((1 << stage) - 1)) << (3 - stage));
      bf_a[i]  = cbuf[idx_a[i]];
      bf_b[i]  = cbuf[idx_b[i]];
      bf_w[i]  = twiddle(idx_w[i]);
    end
  end

  always_comb begin
    nxt = cbuf;
    for (int i = 0; i < 8; i++) begin
      nxt[idx_a[i]] = bf_p[i];
      nxt[idx_b[i]] = bf_m[i];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_bf
    fft16_butterfly u_bf (
      .a (bf_a[g]),
      .b (bf_b[g]),
      .w (bf_w[g]),
      .p (bf_p[g]),
      .m (bf_m[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      fft_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cbuf[i]  <= '0;
        fft_r[i] <= '0;
      end
    end else begin
      fft_valid <= 1'b0;
      if (seen && !data_valid && cnt == 4'd0 && !frame_rdy && state == S_IDLE)
        done <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_rdy) begin
            for (int i = 0; i < N; i++)
              cbuf[i] <= '{re: IW'(signed'(in_buf[bitrev4(4'(i))])) <<< (IFRAC - FRAC), im: '0};
            stage <= '0;
            state <= S_STAGE;
          end
        end
        S_STAGE: begin
          cbuf  <= nxt;
          stage <= stage + 2'd1;
          if (stage == 2'd3) state <= S_OUT;
        end
        S_OUT: begin
          fft_valid <= 1'b1;
          for (int i = 0; i < N; i++)
            fft_r[i] <= {sat16(cbuf[i].re), sat16(cbuf[i].im)};
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fft_d0  = fft_r[0];
  assign fft_d1  = fft_r[1];
  assign fft_d2  = fft_r[2];
  assign fft_d3  = fft_r[3];
  assign fft_d4  = fft_r[4];
  assign fft_d5  = fft_r[5];
  assign fft_d6  = fft_r[6];
  assign fft_d7  = fft_r[7];
  assign fft_d8  = fft_r[8];
  assign fft_d9  = fft_r[9];
  assign fft_d10 = fft_r[10];
  assign fft_d11 = fft_r[11];
  assign fft_d12 = fft_r[12];
  assign fft_d13 = fft_r[13];
  assign fft_d14 = fft_r[14];
  assign fft_d15 = fft_r[15];
endmodule

// File: tb/tb_fft16.sv
// Bench for fft16: directed vector table plus random frames checked against a direct DFT.
module tb_fft16;
  typedef logic [15:0][15:0] frame_t;
  typedef logic [15:0][31:0] bins_t;
  typedef struct packed {
    frame_t x;
    bins_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [15:0] data;
  logic        fft_valid;
  logic        done;
  logic [31:0] d [16];

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int cyc = 0;
  bins_t exp_q[$];
  int    cyc_q[$];

  fft16 dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  function automatic logic [15:0] sat(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Direct DFT of the raw Q8.8 samples; output raw Q8.8, rounded and clamped.
  function automatic bins_t ref_dft(input frame_t x);
    bins_t r;
    real re, im, a;
    for (int k = 0; k < 16; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 16; n++) begin
        a  = 2.0 * 3.14159265358979 * n * k / 16.0;
        re = re + $itor($signed(x[n])) * $cos(a);
        im = im - $itor($signed(x[n])) * $sin(a);
      end
      r[k] = {sat(rnd(re)), sat(rnd(im))};
    end
    return r;
  endfunction

  function automatic bit close(input logic [31:0] a, input logic [31:0] b);
    int dr, di;
    dr = int'($signed(a[31:16])) - int'($signed(b[31:16]));
    di = int'($signed(a[15:0])) - int'($signed(b[15:0]));
    return (dr <= 3 && dr >= -3 && di <= 3 && di >= -3);
  endfunction

  function automatic frame_t rand_frame();
    frame_t x;
    for (int n = 0; n < 16; n++) x[n] = 16'($urandom_range(0, 8191)) - 16'd4096;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input frame_t x, input bins_t e, input bit gaps, input bit expect_out);
    for (int n = 0; n < 16; n++) begin
      if (gaps) idle($urandom_range(0, 2));
      data_valid = 1'b1;
      data = x[n];
      tick();
    end
    data_valid = 1'b0;
    if (expect_out) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 6);
    end
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
    chk(nm, exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : monitor
    bins_t e;
    int    c;
    bit    ok;
    int    bad;
    forever begin
      @(posedge clk);
      #2;
      if (fft_valid === 1'b1) begin
        pulses++;
        chk("expected pulse", exp_q.size() != 0, pulses, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("pulse cycle", cyc == c, cyc, c);
          ok  = 1'b1;
          bad = 0;
          for (int k = 0; k < 16; k++)
            if (!close(d[k], e[k]) && ok) begin
              ok  = 1'b0;
              bad = k;
            end
          chk($sformatf("frame %0d bin %0d", pulses, bad), ok, d[bad], e[bad]);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t   tab [6];
    frame_t x;
    bins_t  e;
    int     base;

    rst = 1'b1;
    data_valid = 1'b0;
    data = '0;
    repeat (3) tick();
    chk("reset fft_valid", fft_valid == 1'b0, 32'(fft_valid), 0);
    chk("reset done", done == 1'b0, 32'(done), 0);
    chk("reset fft_d0", d[0] == 32'h0, d[0], 0);
    chk("reset fft_d15", d[15] == 32'h0, d[15], 0);
    rst = 1'b0;
    tick();

    x = '0; x[0] = 16'h0100;
    tab[0] = '{x: x, e: {16{32'h01000000}}};
    x = {16{16'h0100}}; e = '0; e[0] = 32'h10000000;
    tab[1] = '{x: x, e: e};
    for (int n = 0; n < 16; n++) x[n] = n[0] ? 16'hFF00 : 16'h0100;
    e = '0; e[8] = 32'h10000000;
    tab[2] = '{x: x, e: e};
    for (int n = 0; n < 16; n++) x[n] = 16'(rnd($cos(2.0 * 3.14159265358979 * n / 16.0) * 256.0));
    tab[3] = '{x: x, e: ref_dft(x)};
    x = {16{16'h7FFF}}; e = '0; e[0] = 32'h7FFF0000;
    tab[4] = '{x: x, e: e};
    x = {16{16'h8000}}; e = '0; e[0] = 32'h80000000;
    tab[5] = '{x: x, e: e};

    for (int i = 0; i < 6; i++) begin
      send_frame(tab[i].x, tab[i].e, i == 3, 1'b1);
      idle(3);
    end
    drain("directed drain");
    idle(2);
    chk("done after directed", done == 1'b1, 32'(done), 1);

    x = rand_frame();
    send_frame(x, ref_dft(x), 1'b1, 1'b1);
    chk("done sticky during capture", done == 1'b1, 32'(done), 1);
    drain("post-done frame drain");

    // Partial frame held across an idle gap keeps done low.
    do_reset();
    x = rand_frame();
    for (int n = 0; n < 5; n++) begin
      data_valid = 1'b1; data = x[n]; tick();
    end
    idle(10);
    chk("done low on partial frame", done == 1'b0, 32'(done), 0);
    for (int n = 5; n < 16; n++) begin
      data_valid = 1'b1; data = x[n]; tick();
    end
    data_valid = 1'b0;
    exp_q.push_back(ref_dft(x));
    cyc_q.push_back(cyc + 6);
    drain("split frame drain");

    // Reset mid-frame and mid-compute: neither may produce a pulse.
    base = pulses;
    x = rand_frame();
    for (int n = 0; n < 7; n++) begin
      data_valid = 1'b1; data = x[n]; tick();
    end
    do_reset();
    send_frame(rand_frame(), '0, 1'b0, 1'b0);
    idle(2);
    do_reset();
    idle(12);
    chk("no pulse after reset", pulses == base, pulses, base);
    chk("outputs cleared by reset", d[0] == 32'h0, d[0], 0);
    x = rand_frame();
    send_frame(x, ref_dft(x), 1'b0, 1'b1);
    drain("fresh frame drain");

    // 62 back-to-back random frames.
    do_reset();
    chk("done low after reset", done == 1'b0, 32'(done), 0);
    base = pulses;
    for (int f = 0; f < 62; f++) begin
      x = rand_frame();
      send_frame(x, ref_dft(x), 1'b0, 1'b1);
      if (f == 30) chk("done low mid-stream", done == 1'b0, 32'(done), 0);
    end
    for (int t = 0; t < 40 && pulses < base + 62; t++) begin
      @(posedge clk);
      #3;
    end
    chk("stream pulse count", pulses == base + 62, pulses - base, 62);
    chk("done low at last pulse", done == 1'b0 && fft_valid == 1'b1, {30'd0, fft_valid, done}, 32'h2);
    @(posedge clk);
    #3;
    chk("done one cycle after last pulse", done == 1'b1, 32'(done), 1);
    idle(5);
    chk("done stays high", done == 1'b1, 32'(done), 1);
    chk("no extra pulses", pulses == base + 62 && exp_q.size() == 0, pulses - base, 62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
